vga_multi_ball: RTL and testbench

Parametrised bouncing-sprite engine for the TinyTapeout VGA designs. It replaces the single free-running ball with N independent balls, each with its own position, direction and colour. Positions update once per video frame, synchronised to the frame-start pulse from `hvsync_generator`. Each ball's step is applied in turn on a shared motion datapath. Pixel colour is produced with one registered pipeline stage for the top level to drive onto `uo_out`.

---
 rtl/vga_ball_pkg.sv | 59 +++++
 rtl/ball_hit_test.sv | 30 +++
 rtl/vga_multi_ball.sv | 175 +++++++++++++++++
 tb/tb_vga_multi_ball.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ball_pkg.sv
// Shared types and constants for the multi-ball VGA sprite engine.
// Also holds the per-axis bounce/clamp step used by the shared motion datapath.
package vga_ball_pkg;

  localparam int unsigned COORD_W = 10;

  // Update FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] BG_COLOUR = 6'b00_00_01;

  // white, yellow, cyan, magenta, red, green, blue, gray
  localparam logic [5:0] PALETTE [0:7] = '{
    6'b11_11_11, 6'b11_11_00, 6'b00_11_11, 6'b11_00_11,
    6'b11_00_00, 6'b00_11_00, 6'b00_00_11, 6'b10_10_10
  };

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
    logic               bounce;
  } axis_t;

  // One axis step in 11-bit unsigned; hitting or passing a wall clamps and flips.
  function automatic axis_t axis_step(input logic [COORD_W-1:0] p,
                                      input logic               dir,
                                      input logic [10:0]        spd,
                                      input logic [10:0]        pmin,
                                      input logic [10:0]        pmax);
    axis_t       res;
    logic [10:0] nxt;
    res.pos    = p;
    res.dir    = dir;
    res.bounce = 1'b0;
    if (dir) begin
      nxt = {1'b0, p} + spd;
      if (nxt >= pmax) begin
        res.pos    = pmax[COORD_W-1:0];
        res.dir    = 1'b0;
        res.bounce = 1'b1;
      end else begin
        res.pos = nxt[COORD_W-1:0];
      end
    end else begin
      nxt = pmin + spd;
      if ({1'b0, p} < nxt) begin
        res.pos    = pmin[COORD_W-1:0];
        res.dir    = 1'b1;
        res.bounce = 1'b1;
      end else begin
        res.pos = COORD_W'({1'b0, p} - spd);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ball_hit_test.sv
// Combinational circle test: is the pixel strictly inside the ball of given radius?
module ball_hit_test
  import vga_ball_pkg::*;
#(
  parameter int unsigned RADIUS = 16
) (
  input  logic [COORD_W-1:0] i_pix_x,
  input  logic [COORD_W-1:0] i_pix_y,
  input  logic [COORD_W-1:0] i_ball_x,
  input  logic [COORD_W-1:0] i_ball_y,
  output logic               o_hit
);

  localparam logic [20:0] R_SQ = 21'(RADIUS * RADIUS);

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic signed [21:0] w_sq_x;
  logic signed [21:0] w_sq_y;
  logic        [20:0] w_d2;

  assign w_dx   = $signed({1'b0, i_pix_x}) - $signed({1'b0, i_ball_x});
  assign w_dy   = $signed({1'b0, i_pix_y}) - $signed({1'b0, i_ball_y});
  // Squares of an 11-bit delta are below 2^20, so the 21-bit sum cannot overflow.
  assign w_sq_x = 22'(w_dx) * 22'(w_dx);
  assign w_sq_y = 22'(w_dy) * 22'(w_dy);
  assign w_d2   = 21'(w_sq_x) + 21'(w_sq_y);
  assign o_hit  = (w_d2 < R_SQ);

endmodule

// File: rtl/vga_multi_ball.sv
// N independent bouncing balls: per-frame motion on one shared step datapath,
// one registered render stage producing colour and the covering ball index.
module vga_multi_ball
  import vga_ball_pkg::*;
#(
  parameter int unsigned N_BALLS  = 4,
  parameter int unsigned RADIUS   = 16,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_start,
  input  logic [COORD_W-1:0] i_pix_x,
  input  logic [COORD_W-1:0] i_pix_y,
  input  logic               i_display_on,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_pause,
  output logic [5:0]         o_rgb,
  output logic [2:0]         o_hit_idx,
  output logic               o_hit_valid,
  output logic [15:0]        o_bounce_count,
  output logic               o_busy
);

  localparam logic [10:0] X_MIN = 11'(RADIUS);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] Y_MIN = 11'(RADIUS);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - 1 - RADIUS);

  logic [COORD_W-1:0] r_x [N_BALLS];
  logic [COORD_W-1:0] r_y [N_BALLS];
  logic [N_BALLS-1:0] r_dx;
  logic [N_BALLS-1:0] r_dy;
  logic [1:0]         r_state;
  logic [2:0]         r_idx;
  logic [15:0]        r_bounce;
  logic [5:0]         r_rgb;
  logic [2:0]         r_hit_idx;
  logic               r_hit_valid;

  logic [1:0]         w_state_nxt;
  logic [2:0]         w_idx_nxt;
  logic [COORD_W-1:0] w_cur_x;
  logic [COORD_W-1:0] w_cur_y;
  logic               w_cur_dx;
  logic               w_cur_dy;
  logic [10:0]        w_spd;
  axis_t              w_step_x;
  axis_t              w_step_y;
  logic [N_BALLS-1:0] w_hit;
  logic               w_any;
  logic [2:0]         w_win;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_start && !i_pause && (i_speed != '0)) begin
          w_state_nxt = ST_STEP;
          w_idx_nxt   = 3'd0;
        end
      end
      ST_STEP: begin
        if (r_idx == 3'(N_BALLS - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cur_x  = '0;
    w_cur_y  = '0;
    w_cur_dx = 1'b0;
    w_cur_dy = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (r_idx == 3'(i)) begin
        w_cur_x  = r_x[i];
        w_cur_y  = r_y[i];
        w_cur_dx = r_dx[i];
        w_cur_dy = r_dy[i];
      end
    end
  end

  assign w_spd    = 11'(i_speed);
  assign w_step_x = axis_step(w_cur_x, w_cur_dx, w_spd, X_MIN, X_MAX);
  assign w_step_y = axis_step(w_cur_y, w_cur_dy, w_spd, Y_MIN, Y_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_bounce <= 16'd0;
      for (int i = 0; i < N_BALLS; i++) begin
        r_x[i]  <= COORD_W'(RADIUS + 32 * i);
        r_y[i]  <= COORD_W'(RADIUS + 24 * i);
        r_dx[i] <= 1'(i % 2);
        r_dy[i] <= 1'((i / 2) % 2);
      end
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == ST_STEP) begin
        for (int i = 0; i < N_BALLS; i++) begin
          if (r_idx == 3'(i)) begin
            r_x[i]  <= w_step_x.pos;
            r_y[i]  <= w_step_y.pos;
            r_dx[i] <= w_step_x.dir;
            r_dy[i] <= w_step_y.dir;
          end
        end
        // A corner hit bounces both axes and counts twice.
        r_bounce <= r_bounce + 16'(w_step_x.bounce) + 16'(w_step_y.bounce);
      end
    end
  end

  for (genvar g = 0; g < N_BALLS; g++) begin : g_hit
    ball_hit_test #(
      .RADIUS(RADIUS)
    ) u_hit (
      .i_pix_x  (i_pix_x),
      .i_pix_y  (i_pix_y),
      .i_ball_x (r_x[g]),
      .i_ball_y (r_y[g]),
      .o_hit    (w_hit[g])
    );
  end

  // Scan high to low so the lowest-index covering ball wins.
  always_comb begin
    w_any = 1'b0;
    w_win = 3'd0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_win = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb       <= 6'd0;
      r_hit_idx   <= 3'd0;
      r_hit_valid <= 1'b0;
    end else if (!i_display_on) begin
      r_rgb       <= 6'd0;
      r_hit_idx   <= 3'd0;
      r_hit_valid <= 1'b0;
    end else if (w_any) begin
      r_rgb       <= PALETTE[w_win];
      r_hit_idx   <= w_win;
      r_hit_valid <= 1'b1;
    end else begin
      r_rgb       <= BG_COLOUR;
      r_hit_idx   <= 3'd0;
      r_hit_valid <= 1'b0;
    end
  end

  assign o_rgb          = r_rgb;
  assign o_hit_idx      = r_hit_idx;
  assign o_hit_valid    = r_hit_valid;
  assign o_bounce_count = r_bounce;
  assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vga_multi_ball.sv
// Scoreboard bench for vga_multi_ball: a behavioural ball model predicts motion
// and render output; a second small-arena instance drives bounce_count through its wrap.
module tb_vga_multi_ball;

  localparam int N  = 4;
  localparam int R  = 16;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int NW = 8;
  localparam int RW = 4;
  localparam int HW = 9;
  localparam int VW = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_start_w = 1'b0;
  logic        display_on = 1'b0;
  logic        pause = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [2:0]  speed = '0;
  logic [5:0]  rgb, rgb_w;
  logic [2:0]  hit_idx, hit_idx_w;
  logic        hit_valid, hit_valid_w;
  logic [15:0] bounce_count, bounce_count_w;
  logic        busy, busy_w;

  always #5 clk = ~clk;

  vga_multi_ball #(
    .N_BALLS(N), .RADIUS(R), .H_ACTIVE(H), .V_ACTIVE(V), .SPEED_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start), .i_pix_x(pix_x),
    .i_pix_y(pix_y), .i_display_on(display_on), .i_speed(speed), .i_pause(pause),
    .o_rgb(rgb), .o_hit_idx(hit_idx), .o_hit_valid(hit_valid),
    .o_bounce_count(bounce_count), .o_busy(busy)
  );

  vga_multi_ball #(
    .N_BALLS(NW), .RADIUS(RW), .H_ACTIVE(HW), .V_ACTIVE(VW), .SPEED_W(3)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start_w), .i_pix_x(10'd0),
    .i_pix_y(10'd0), .i_display_on(1'b0), .i_speed(speed), .i_pause(pause),
    .o_rgb(rgb_w), .o_hit_idx(hit_idx_w), .o_hit_valid(hit_valid_w),
    .o_bounce_count(bounce_count_w), .o_busy(busy_w)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  logic [5:0] pal [8] = '{6'b111111, 6'b111100, 6'b001111, 6'b110011,
                          6'b110000, 6'b001100, 6'b000011, 6'b101010};

  int mx [N];
  int my [N];
  bit mdx [N];
  bit mdy [N];
  int mbc;
  int wx [NW];
  int wy [NW];
  bit wdx [NW];
  bit wdy [NW];
  int wbc;

  function automatic void axis(inout int p, inout bit d, input int spd, input int lo,
                               input int hi, inout int bc);
    if (d) begin
      if (p + spd >= hi) begin p = hi; d = 1'b0; bc++; end
      else p = p + spd;
    end else begin
      if (p - spd < lo) begin p = lo; d = 1'b1; bc++; end
      else p = p - spd;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = R + 32 * i; my[i] = R + 24 * i; mdx[i] = (i % 2) == 1; mdy[i] = ((i / 2) % 2) == 1;
    end
    for (int i = 0; i < NW; i++) begin
      wx[i] = RW + 32 * i; wy[i] = RW + 24 * i; wdx[i] = (i % 2) == 1; wdy[i] = ((i / 2) % 2) == 1;
    end
    mbc = 0;
    wbc = 0;
  endtask

  task automatic model_frame(input int spd);
    for (int i = 0; i < N; i++) begin
      int p; bit d;
      p = mx[i]; d = mdx[i]; axis(p, d, spd, R, H - 1 - R, mbc); mx[i] = p; mdx[i] = d;
      p = my[i]; d = mdy[i]; axis(p, d, spd, R, V - 1 - R, mbc); my[i] = p; mdy[i] = d;
    end
  endtask

  task automatic model_frame_w(input int spd);
    for (int i = 0; i < NW; i++) begin
      int p; bit d;
      p = wx[i]; d = wdx[i]; axis(p, d, spd, RW, HW - 1 - RW, wbc); wx[i] = p; wdx[i] = d;
      p = wy[i]; d = wdy[i]; axis(p, d, spd, RW, VW - 1 - RW, wbc); wy[i] = p; wdy[i] = d;
    end
  endtask

  // Packed expectation: {hit_valid, hit_idx[2:0], rgb[5:0]}
  function automatic logic [9:0] exp_pix(input int px, input int py, input bit on);
    if (!on) return 10'd0;
    for (int i = 0; i < N; i++) begin
      int ddx, ddy;
      ddx = px - mx[i];
      ddy = py - my[i];
      if (ddx * ddx + ddy * ddy < R * R) return {1'b1, 3'(i), pal[i]};
    end
    return {1'b0, 3'b000, 6'b000001};
  endfunction

  logic [9:0] sb_q [$];

  // Each pixel pushed at a negedge is registered at the next posedge and popped just after.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      logic [9:0] e;
      e = sb_q.pop_front();
      check_eq("rgb", 32'(rgb), 32'(e[5:0]));
      check_eq("hit_idx", 32'(hit_idx), 32'(e[8:6]));
      check_eq("hit_valid", 32'(hit_valid), 32'(e[9]));
    end
  end

  task automatic drive_pix(input int px, input int py, input bit on);
    @(negedge clk);
    pix_x = 10'(px);
    pix_y = 10'(py);
    display_on = on;
    sb_q.push_back(exp_pix(px, py, on));
  endtask

  task automatic render_sweep();
    for (int i = 0; i < N; i++) begin
      drive_pix(mx[i], my[i], 1'b1);
      drive_pix(mx[i] + R - 1, my[i], 1'b1);
      drive_pix(mx[i] + R, my[i], 1'b1);
      drive_pix(mx[i], my[i] - R + 1, 1'b1);
      drive_pix(mx[i], my[i], 1'b0);
    end
    drive_pix(50, 40, 1'b1);
    drive_pix(50, 40, 1'b0);
    for (int k = 0; k < 6; k++) drive_pix($urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'b1);
    @(negedge clk);
    display_on = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_x%0d", tag, i), 32'(dut.r_x[i]), 32'(mx[i]));
      check_eq($sformatf("%s_y%0d", tag, i), 32'(dut.r_y[i]), 32'(my[i]));
      check_eq($sformatf("%s_dx%0d", tag, i), 32'(dut.r_dx[i]), 32'(mdx[i]));
      check_eq($sformatf("%s_dy%0d", tag, i), 32'(dut.r_dy[i]), 32'(mdy[i]));
    end
    check_eq({tag, "_bounce"}, 32'(bounce_count), 32'(mbc % 65536));
  endtask

  // Pulse frame_start, count busy cycles; dbl adds a second pulse mid-update.
  task automatic run_frame(input int spd, input bit pse, input bit dbl, input string tag);
    int  bcnt;
    bit  acc;
    @(negedge clk);
    speed = 3'(spd); pause = pse; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    bcnt = busy ? 1 : 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      frame_start = (dbl && k == 1);
    end
    frame_start = 1'b0;
    acc = (spd != 0) && !pse;
    if (acc) model_frame(spd);
    check_eq({tag, "_busy_cycles"}, 32'(bcnt), acc ? 32'(N + 1) : 32'd0);
    check_state(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_rgb", 32'(rgb), 32'd0);
    check_eq("rst_hit_valid", 32'(hit_valid), 32'd0);
    check_eq("rst_hit_idx", 32'(hit_idx), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_x1", 32'(dut.r_x[1]), 32'd48);
    check_eq("rst_y3", 32'(dut.r_y[3]), 32'd88);
    check_state("rst");
    rst_n = 1'b1;

    render_sweep();

    // Ball 0 sits in the top-left corner moving up-left: both axes clamp and bounce.
    run_frame(7, 1'b0, 1'b0, "f1");
    check_eq("f1_x0_const", 32'(dut.r_x[0]), 32'd16);
    check_eq("f1_y0_const", 32'(dut.r_y[0]), 32'd16);
    check_eq("f1_x1_const", 32'(dut.r_x[1]), 32'd55);
    check_eq("f1_y1_const", 32'(dut.r_y[1]), 32'd33);
    check_eq("f1_bounce_const", 32'(bounce_count), 32'd2);

    for (int f = 0; f < 3; f++) run_frame(5, 1'b1, 1'b0, "pause");
    for (int f = 0; f < 3; f++) run_frame(0, 1'b0, 1'b0, "speed0");
    run_frame(4, 1'b0, 1'b1, "dbl");

    for (int f = 0; f < 110; f++) run_frame(1 + (f % 7), 1'b0, 1'b0, "run");
    render_sweep();

    // Reset during the second STEP cycle.
    @(negedge clk);
    speed = 3'd5; pause = 1'b0; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_rgb", 32'(rgb), 32'd0);
    check_state("midrst");
    run_frame(3, 1'b0, 1'b0, "post_rst");

    // Small arena: every ball ends up bouncing on both axes each frame.
    speed = 3'd7;
    pause = 1'b0;
    while (wbc < 65560) begin
      @(negedge clk);
      frame_start_w = 1'b1;
      @(negedge clk);
      frame_start_w = 1'b0;
      repeat (NW + 2) @(negedge clk);
      model_frame_w(7);
      if (wbc >= 65500) check_eq("wrap_bounce", 32'(bounce_count_w), 32'(wbc % 65536));
    end
    check_eq("wrap_idle", 32'(busy_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
